mpu_sequencer: RTL and testbench

MPU_SEQUENCER -- requirements
Module: mpu_sequencer

---
 rtl/mpu_sequencer_if.sv | 36 +++
 rtl/mpu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mpu_sequencer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mpu_sequencer_if                                                     |
// | Memory port and operation-unit port of the MPU sequencer.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mpu_sequencer_if #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int AW = 3
);
  localparam int D = N * N * W;

  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [D-1:0]  mem_wdata;
  logic [D-1:0]  mem_rdata;
  logic [D-1:0]  matrix_a;
  logic [D-1:0]  matrix_b;
  logic [2:0]    op_opcode;
  logic          op_start;
  logic          op_done;
  logic [D-1:0]  op_result;

  modport master (
    output mem_addr, mem_wren, mem_wdata, matrix_a, matrix_b, op_opcode, op_start,
    input  mem_rdata, op_done, op_result
  );

  modport slave (
    input  mem_addr, mem_wren, mem_wdata, matrix_a, matrix_b, op_opcode, op_start,
    output mem_rdata, op_done, op_result
  );
endinterface
`default_nettype wire

// File: rtl/mpu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mpu_sequencer                                                        |
// | Load A, load B, run the operation unit, store the result.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mpu_sequencer #(
  parameter int N       = 5,
  parameter int W       = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 64
) (
  input  wire             clk,
  input  wire             rst_n,
  input  wire             start,
  input  wire [2:0]       opcode,
  input  wire [AW-1:0]    base_a,
  input  wire [AW-1:0]    base_b,
  input  wire [AW-1:0]    base_r,
  mpu_sequencer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      state
);
  localparam int c_d  = N * N * W;
  localparam int c_cw = $clog2(TIMEOUT);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    LD_A = 3'd2,
    RD_B = 3'd3,
    LD_B = 3'd4,
    EXEC = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t          r_state,     w_state_next;
  logic [2:0]      r_opcode,    w_opcode_next;
  logic [AW-1:0]   r_base_a,    w_base_a_next;
  logic [AW-1:0]   r_base_b,    w_base_b_next;
  logic [AW-1:0]   r_base_r,    w_base_r_next;
  logic [AW-1:0]   r_mem_addr,  w_mem_addr_next;
  logic            r_mem_wren,  w_mem_wren_next;
  logic [c_d-1:0]  r_mem_wdata, w_mem_wdata_next;
  logic [c_d-1:0]  r_matrix_a,  w_matrix_a_next;
  logic [c_d-1:0]  r_matrix_b,  w_matrix_b_next;
  logic            r_op_start,  w_op_start_next;
  logic            r_done,      w_done_next;
  logic            r_err,       w_err_next;
  logic [c_cw-1:0] r_cnt,       w_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_opcode    <= '0;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_base_r    <= '0;
      r_mem_addr  <= '0;
      r_mem_wren  <= 1'b0;
      r_mem_wdata <= '0;
      r_matrix_a  <= '0;
      r_matrix_b  <= '0;
      r_op_start  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_opcode    <= w_opcode_next;
      r_base_a    <= w_base_a_next;
      r_base_b    <= w_base_b_next;
      r_base_r    <= w_base_r_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wren  <= w_mem_wren_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_matrix_a  <= w_matrix_a_next;
      r_matrix_b  <= w_matrix_b_next;
      r_op_start  <= w_op_start_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      r_cnt       <= w_cnt_next;
    end
  end

  // Pulse outputs default low; everything else holds unless a state updates it.
  always_comb begin
    w_state_next     = r_state;
    w_opcode_next    = r_opcode;
    w_base_a_next    = r_base_a;
    w_base_b_next    = r_base_b;
    w_base_r_next    = r_base_r;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wren_next  = 1'b0;
    w_mem_wdata_next = r_mem_wdata;
    w_matrix_a_next  = r_matrix_a;
    w_matrix_b_next  = r_matrix_b;
    w_op_start_next  = 1'b0;
    w_done_next      = 1'b0;
    w_err_next       = r_err;
    w_cnt_next       = r_cnt;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_opcode_next   = opcode;
          w_base_a_next   = base_a;
          w_base_b_next   = base_b;
          w_base_r_next   = base_r;
          w_err_next      = 1'b0;
          w_mem_addr_next = base_a;
          w_state_next    = RD_A;
        end
      end
      RD_A: w_state_next = LD_A;
      LD_A: begin
        w_matrix_a_next = bus.mem_rdata;
        w_mem_addr_next = r_base_b;
        w_state_next    = RD_B;
      end
      RD_B: w_state_next = LD_B;
      LD_B: begin
        w_matrix_b_next = bus.mem_rdata;
        w_op_start_next = 1'b1;
        w_cnt_next      = '0;
        w_state_next    = EXEC;
      end
      EXEC: begin
        // A completion on the last allowed cycle still takes the write path.
        if (bus.op_done) begin
          w_mem_wdata_next = bus.op_result;
          w_mem_addr_next  = r_base_r;
          w_mem_wren_next  = 1'b1;
          w_state_next     = WR;
        end else if (r_cnt == c_cnt_last) begin
          w_err_next   = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WR: begin
        w_done_next  = 1'b1;
        w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wren  = r_mem_wren;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.matrix_a  = r_matrix_a;
  assign bus.matrix_b  = r_matrix_b;
  assign bus.op_opcode = r_opcode;
  assign bus.op_start  = r_op_start;

  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign err   = r_err;
  assign state = r_state;
endmodule
`default_nettype wire

// File: tb/tb_mpu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mpu_sequencer                                                     |
// | Two lockstep sequencers (5x5x8 and 3x3x16) against a matrix model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mpu_sequencer;
  localparam int AW = 3;
  localparam int TO = 8;
  localparam int N1 = 5;
  localparam int W1 = 8;
  localparam int D1 = N1 * N1 * W1;
  localparam int N2 = 3;
  localparam int W2 = 16;
  localparam int D2 = N2 * N2 * W2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    opcode;
  logic [AW-1:0] base_a, base_b, base_r;
  logic          busy1, done1, err1, busy2, done2, err2;
  logic [2:0]    state1, state2;

  mpu_sequencer_if #(.N(N1), .W(W1), .AW(AW)) bus1 ();
  mpu_sequencer_if #(.N(N2), .W(W2), .AW(AW)) bus2 ();

  mpu_sequencer #(.N(N1), .W(W1), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .base_a(base_a), .base_b(base_b), .base_r(base_r), .bus(bus1.master),
    .busy(busy1), .done(done1), .err(err1), .state(state1));

  mpu_sequencer #(.N(N2), .W(W2), .AW(AW), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .base_a(base_a), .base_b(base_b), .base_r(base_r), .bus(bus2.master),
    .busy(busy2), .done(done2), .err(err2), .state(state2));

  always #5 clk = ~clk;

  // Synchronous RAMs with a bench-side preload port.
  logic [D1-1:0] ram1 [8];
  logic [D2-1:0] ram2 [8];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [D1-1:0] pl_d1;
  logic [D2-1:0] pl_d2;

  always @(posedge clk) begin
    if (pl_en) begin
      ram1[pl_addr] <= pl_d1;
      ram2[pl_addr] <= pl_d2;
    end
    if (bus1.mem_wren) ram1[bus1.mem_addr] <= bus1.mem_wdata;
    if (bus2.mem_wren) ram2[bus2.mem_addr] <= bus2.mem_wdata;
    bus1.mem_rdata <= ram1[bus1.mem_addr];
    bus2.mem_rdata <= ram2[bus2.mem_addr];
  end

  logic [D1-1:0] mram1 [8];
  logic [D2-1:0] mram2 [8];
  int lat, ecnt;
  bit spur;
  int trace[$];
  int n_wren, n_done, n_ostart, ostart_idx, wren_idx, done_idx, cap_err0;
  int n_cmp, n_err;

  // Result(i,j) combines A(i,j) with B(j,i), so any transposition shows up.
  function automatic logic [D1-1:0] op_model(input int n, input int w, input logic [2:0] opc,
                                             input logic [D1-1:0] a, input logic [D1-1:0] b);
    logic [D1-1:0] res;
    logic [15:0]   ea, eb, r, mask;
    res  = '0;
    mask = 16'((32'd1 << w) - 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        ea = 16'(a >> ((i * n + j) * w)) & mask;
        eb = 16'(b >> ((j * n + i) * w)) & mask;
        case (opc[1:0])
          2'd0:    r = ea + eb;
          2'd1:    r = ea - eb;
          2'd2:    r = ea ^ eb;
          default: r = ea + 16'(opc);
        endcase
        res = res | (D1'(r & mask) << ((i * n + j) * w));
      end
    end
    return res;
  endfunction

  function automatic logic [D1-1:0] rnd1();
    logic [D1-1:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) v = {v[D1-33:0], $urandom()};
    return v;
  endfunction

  function automatic string trace_str();
    string s;
    s = "";
    foreach (trace[k]) s = {s, $sformatf("%0d", trace[k])};
    return s;
  endfunction

  function automatic string exp_str(input int nexec, input bit ok);
    string s;
    s = "1234";
    for (int k = 0; k < nexec; k++) s = {s, "5"};
    if (ok) s = {s, "67"};
    else    s = {s, "7"};
    s = {s, "0"};
    return s;
  endfunction

  // One cycle: sample at the falling edge, then act as the operation unit.
  task automatic step();
    @(negedge clk);
    if (bus1.op_start && ostart_idx < 0) ostart_idx = trace.size();
    if (bus1.mem_wren && wren_idx < 0)   wren_idx   = trace.size();
    if (done1 && done_idx < 0)           done_idx   = trace.size();
    trace.push_back(int'(state1));
    if (bus1.mem_wren) n_wren++;
    if (done1)         n_done++;
    if (bus1.op_start) n_ostart++;
    if (bus1.op_start) ecnt = 1;
    else if (ecnt > 0) ecnt++;
    bus1.op_done   = spur || (lat > 0 && ecnt == lat);
    bus2.op_done   = bus1.op_done;
    bus1.op_result = op_model(N1, W1, bus1.op_opcode, bus1.matrix_a, bus1.matrix_b);
    bus2.op_result = D2'(op_model(N2, W2, bus2.op_opcode, D1'(bus2.matrix_a), D1'(bus2.matrix_b)));
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [D1-1:0] d1, input logic [D2-1:0] d2);
    pl_en = 1'b1; pl_addr = a; pl_d1 = d1; pl_d2 = d2;
    step();
    pl_en = 1'b0;
    mram1[a] = d1;
    mram2[a] = d2;
  endtask

  task automatic run_seq(input logic [2:0] opc, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                         input logic [AW-1:0] br, input int l, input bit spam);
    int cyc;
    trace.delete();
    n_wren = 0; n_done = 0; n_ostart = 0; ostart_idx = -1; wren_idx = -1; done_idx = -1;
    lat = l;
    opcode = opc; base_a = ba; base_b = bb; base_r = br; start = 1'b1;
    step();
    cap_err0 = int'(err1);
    cyc = 0;
    while (state1 != 3'd0 && cyc < 64) begin
      start = spam;
      if (spam) begin
        opcode = 3'($urandom); base_a = AW'($urandom); base_b = AW'($urandom); base_r = AW'($urandom);
      end
      step();
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (cyc >= 64) begin
      n_err++;
      $display("FAIL seq_bound: state=%0d after 64 cycles, required 0", state1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int a = 0; a < 8; a++) preload(AW'(a), rnd1(), D2'(rnd1()));
    n_cmp++;
    if (state1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: state=%0d busy=%b done=%b err=%b, required 0 0 0 0", state1, busy1, done1, err1);
    end
    n_cmp++;
    if (bus1.mem_wren !== 1'b0 || bus1.op_start !== 1'b0 || bus1.mem_addr !== '0 || bus1.op_opcode !== '0) begin
      n_err++;
      $display("FAIL reset_bus: wren=%b op_start=%b addr=%0d opcode=%0d, required all 0",
               bus1.mem_wren, bus1.op_start, bus1.mem_addr, bus1.op_opcode);
    end
    n_cmp++;
    if (bus1.matrix_a !== '0 || bus1.matrix_b !== '0 || bus1.mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_data: a=%h b=%h wdata=%h, required 0", bus1.matrix_a, bus1.matrix_b, bus1.mem_wdata);
    end
  endtask

  task automatic test_directed();
    logic [D1-1:0] er;
    er = op_model(N1, W1, 3'd2, mram1[0], mram1[1]);
    rst_n = 1'b1;
    run_seq(3'd2, 3'd0, 3'd1, 3'd2, 3, 1'b0);
    n_cmp++;
    if (trace_str() != exp_str(3, 1'b1)) begin
      n_err++;
      $display("FAIL dir_trace: got %s, required %s", trace_str(), exp_str(3, 1'b1));
    end
    n_cmp++;
    if (ram1[2] !== er) begin
      n_err++;
      $display("FAIL dir_result: got %h, required %h", ram1[2], er);
    end
    n_cmp++;
    if (n_wren != 1 || n_done != 1 || n_ostart != 1) begin
      n_err++;
      $display("FAIL dir_pulses: wren=%0d done=%0d op_start=%0d cycles, required 1 1 1", n_wren, n_done, n_ostart);
    end
    n_cmp++;
    if (ostart_idx != 4 || wren_idx != 7 || done_idx != 8) begin
      n_err++;
      $display("FAIL dir_latency: op_start@%0d wren@%0d done@%0d, required 4 7 8", ostart_idx, wren_idx, done_idx);
    end
    n_cmp++;
    if (err1 !== 1'b0 || bus1.op_opcode !== 3'd2) begin
      n_err++;
      $display("FAIL dir_status: err=%b opcode=%0d, required 0 2", err1, bus1.op_opcode);
    end
    mram1[2] = er;
    mram2[2] = D2'(op_model(N2, W2, 3'd2, D1'(mram2[0]), D1'(mram2[1])));
  endtask

  task automatic test_random();
    logic [2:0]    opc;
    logic [AW-1:0] ba, bb, br;
    logic [D1-1:0] ea, eb, er;
    int            l;
    for (int it = 0; it < 6; it++) begin
      preload(AW'($urandom), rnd1(), D2'(rnd1()));
      opc = 3'($urandom); ba = AW'($urandom); bb = AW'($urandom); br = AW'($urandom);
      l = $urandom_range(1, TO);
      ea = mram1[ba]; eb = mram1[bb];
      er = op_model(N1, W1, opc, ea, eb);
      run_seq(opc, ba, bb, br, l, 1'b0);
      n_cmp++;
      if (trace_str() != exp_str(l, 1'b1)) begin
        n_err++;
        $display("FAIL rnd_trace[%0d]: got %s, required %s", it, trace_str(), exp_str(l, 1'b1));
      end
      n_cmp++;
      if (ram1[br] !== er) begin
        n_err++;
        $display("FAIL rnd_result[%0d]: got %h, required %h", it, ram1[br], er);
      end
      n_cmp++;
      if (bus1.matrix_a !== ea || bus1.matrix_b !== eb) begin
        n_err++;
        $display("FAIL rnd_operands[%0d]: a=%h b=%h, required %h %h", it, bus1.matrix_a, bus1.matrix_b, ea, eb);
      end
      n_cmp++;
      if (n_wren != 1 || n_done != 1 || err1 !== 1'b0 || bus1.op_opcode !== opc) begin
        n_err++;
        $display("FAIL rnd_status[%0d]: wren=%0d done=%0d err=%b opcode=%0d, required 1 1 0 %0d",
                 it, n_wren, n_done, err1, bus1.op_opcode, opc);
      end
      mram2[br] = D2'(op_model(N2, W2, opc, D1'(mram2[ba]), D1'(mram2[bb])));
      mram1[br] = er;
    end
  endtask

  task automatic test_timeout();
    logic [D1-1:0] er;
    run_seq(3'd0, 3'd0, 3'd1, 3'd2, 0, 1'b0);
    n_cmp++;
    if (trace_str() != exp_str(TO, 1'b0)) begin
      n_err++;
      $display("FAIL to_trace: got %s, required %s", trace_str(), exp_str(TO, 1'b0));
    end
    n_cmp++;
    if (err1 !== 1'b1 || n_wren != 0 || n_done != 1 || done_idx != 4 + TO) begin
      n_err++;
      $display("FAIL to_status: err=%b wren=%0d done=%0d done@%0d, required 1 0 1 %0d", err1, n_wren, n_done, done_idx, 4 + TO);
    end
    n_cmp++;
    if (ram1[2] !== mram1[2]) begin
      n_err++;
      $display("FAIL to_nowrite: ram[2]=%h, required %h", ram1[2], mram1[2]);
    end
    repeat (3) step();
    n_cmp++;
    if (err1 !== 1'b1 || state1 !== 3'd0) begin
      n_err++;
      $display("FAIL to_hold: err=%b state=%0d, required 1 0", err1, state1);
    end
    er = op_model(N1, W1, 3'd1, mram1[0], mram1[1]);
    run_seq(3'd1, 3'd0, 3'd1, 3'd2, 2, 1'b0);
    n_cmp++;
    if (cap_err0 != 0 || err1 !== 1'b0 || ram1[2] !== er) begin
      n_err++;
      $display("FAIL to_recover: err@accept=%0d err=%b ram[2]=%h, required 0 0 %h", cap_err0, err1, ram1[2], er);
    end
    mram1[2] = er;
    mram2[2] = D2'(op_model(N2, W2, 3'd1, D1'(mram2[0]), D1'(mram2[1])));
  endtask

  task automatic test_timeout_edge();
    logic [D1-1:0] er;
    er = op_model(N1, W1, 3'd3, mram1[4], mram1[5]);
    run_seq(3'd3, 3'd4, 3'd5, 3'd6, TO, 1'b0);
    n_cmp++;
    if (trace_str() != exp_str(TO, 1'b1)) begin
      n_err++;
      $display("FAIL edge_trace: got %s, required %s", trace_str(), exp_str(TO, 1'b1));
    end
    n_cmp++;
    if (err1 !== 1'b0 || n_wren != 1 || ram1[6] !== er) begin
      n_err++;
      $display("FAIL edge_write: err=%b wren=%0d ram[6]=%h, required 0 1 %h", err1, n_wren, ram1[6], er);
    end
    mram1[6] = er;
    mram2[6] = D2'(op_model(N2, W2, 3'd3, D1'(mram2[4]), D1'(mram2[5])));
  endtask

  task automatic test_busy_start();
    logic [D1-1:0] er;
    int            w0;
    er = op_model(N1, W1, 3'd5, mram1[7], mram1[3]);
    run_seq(3'd5, 3'd7, 3'd3, 3'd1, 4, 1'b1);
    n_cmp++;
    if (trace_str() != exp_str(4, 1'b1) || n_ostart != 1) begin
      n_err++;
      $display("FAIL busy_trace: got %s op_start=%0d, required %s 1", trace_str(), n_ostart, exp_str(4, 1'b1));
    end
    n_cmp++;
    if (ram1[1] !== er || bus1.op_opcode !== 3'd5) begin
      n_err++;
      $display("FAIL busy_latched: ram[1]=%h opcode=%0d, required %h 5", ram1[1], bus1.op_opcode, er);
    end
    mram1[1] = er;
    mram2[1] = D2'(op_model(N2, W2, 3'd5, D1'(mram2[7]), D1'(mram2[3])));
    w0 = n_wren;
    spur = 1'b1;
    repeat (3) step();
    spur = 1'b0;
    step();
    n_cmp++;
    if (state1 !== 3'd0 || n_wren != w0) begin
      n_err++;
      $display("FAIL busy_noqueue: state=%0d extra wren=%0d, required 0 0", state1, n_wren - w0);
    end
  endtask

  task automatic test_reset_mid();
    int            k;
    logic [D1-1:0] er;
    opcode = 3'd1; base_a = 3'd0; base_b = 3'd1; base_r = 3'd5; lat = 3; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (state1 !== 3'd5 && k < 12) begin step(); k++; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state1 !== 3'd0 || busy1 !== 1'b0 || bus1.op_start !== 1'b0 || bus1.matrix_a !== '0 || bus1.matrix_b !== '0) begin
      n_err++;
      $display("FAIL rst_exec: state=%0d busy=%b op_start=%b a=%h, required 0 0 0 0", state1, busy1, bus1.op_start, bus1.matrix_a);
    end
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (state1 !== 3'd6 && k < 20) begin step(); k++; end
    n_cmp++;
    if (bus1.mem_wren !== 1'b1) begin
      n_err++;
      $display("FAIL rst_wr_pre: wren=%b in state %0d, required 1 in state 6", bus1.mem_wren, state1);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus1.mem_wren !== 1'b0 || state1 !== 3'd0 || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wr: wren=%b state=%0d done=%b, required 0 0 0", bus1.mem_wren, state1, done1);
    end
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (ram1[5] !== mram1[5] || state1 !== 3'd0) begin
      n_err++;
      $display("FAIL rst_nowrite: ram[5]=%h state=%0d, required %h 0", ram1[5], state1, mram1[5]);
    end
    er = op_model(N1, W1, 3'd1, mram1[0], mram1[1]);
    run_seq(3'd1, 3'd0, 3'd1, 3'd5, 2, 1'b0);
    n_cmp++;
    if (trace_str() != exp_str(2, 1'b1) || ram1[5] !== er) begin
      n_err++;
      $display("FAIL rst_fresh: trace %s ram[5]=%h, required %s %h", trace_str(), ram1[5], exp_str(2, 1'b1), er);
    end
    mram1[5] = er;
    mram2[5] = D2'(op_model(N2, W2, 3'd1, D1'(mram2[0]), D1'(mram2[1])));
  endtask

  task automatic test_n3();
    logic [D2-1:0] a2, b2, v2, er2;
    logic [W2-1:0] e21;
    for (int i = 0; i < N2; i++) begin
      for (int j = 0; j < N2; j++) begin
        a2[(i * N2 + j) * W2 +: W2] = 16'hA000 | 16'(i * 16 + j);
        b2[(i * N2 + j) * W2 +: W2] = 16'h0B00 | 16'(i * 16 + j);
      end
    end
    preload(3'd3, rnd1(), a2);
    preload(3'd4, rnd1(), b2);
    er2 = D2'(op_model(N2, W2, 3'd0, D1'(a2), D1'(b2)));
    run_seq(3'd0, 3'd3, 3'd4, 3'd6, 2, 1'b0);
    v2  = ram2[6];
    e21 = v2[(2 * N2 + 1) * W2 +: W2];
    n_cmp++;
    if (e21 !== 16'hAB33) begin
      n_err++;
      $display("FAIL n3_elem21: got %h, required ab33", e21);
    end
    n_cmp++;
    if (v2 !== er2 || bus2.matrix_a !== a2) begin
      n_err++;
      $display("FAIL n3_result: got %h a=%h, required %h %h", v2, bus2.matrix_a, er2, a2);
    end
    mram1[6] = op_model(N1, W1, 3'd0, mram1[3], mram1[4]);
    mram2[6] = er2;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; lat = 0; ecnt = 0; spur = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_d1 = '0; pl_d2 = '0;
    start = 1'b0; opcode = '0; base_a = '0; base_b = '0; base_r = '0; rst_n = 1'b0;
    bus1.op_done = 1'b0; bus1.op_result = '0; bus2.op_done = 1'b0; bus2.op_result = '0;
    ostart_idx = -1; wren_idx = -1; done_idx = -1; cap_err0 = 0;
    n_wren = 0; n_done = 0; n_ostart = 0;
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_timeout_edge();
    test_busy_start();
    test_reset_mid();
    test_n3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
